risc_step_checker: RTL and testbench
====================================

Name: risc_step_checker

Overview:
Synthesizable, parametrised single-step controller and self-checker for the Risc16 core. It replaces a hand-written stepped bench: it issues one-instruction step pulses to the core, captures each commit (register write, memory store or next-PC), and compares it against a loadable expectation table. It reports a pass/fail verdict, an error count and the index of the first failure. It sits beside the core at top level; the core advances only on step pulses.

Parameters:
DATA_WIDTH, 16, width of commit data and expected data
ADDR_WIDTH, 16, width of commit target (register index, memory address or PC)
NUM_CHECKS, 16, depth of expectation table (power of two, >= 2)
TIMEOUT_CYCLES, 8, max cycles from step pulse to commit before declaring timeout (>= 1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run from entry 0
num_steps  in  $clog2(NUM_CHECKS)+1  entries to run, 1..NUM_CHECKS, sampled on start
exp_we  in  1  expectation table write enable (ignored while busy)
exp_idx  in  $clog2(NUM_CHECKS)  table write index
exp_kind  in  2  00 REG, 01 MEM, 10 PC, 11 SKIP (no compare)
exp_target  in  ADDR_WIDTH  expected register index / memory address / unused for PC
exp_data  in  DATA_WIDTH  expected value
cpu_step  out  1  one-cycle clock-enable pulse to core
commit_valid  in  1  core commit strobe, one cycle per instruction
commit_kind  in  2  encoding as exp_kind (never 11)
commit_target  in  ADDR_WIDTH  register/address written
commit_data  in  DATA_WIDTH  value written, or pc_next for kind PC
busy  out  1  run in progress
done  out  1  run finished; held until next start
pass  out  1  valid when done: err_count == 0
err_count  out  $clog2(NUM_CHECKS)+1  mismatches plus timeouts, saturating
fail_idx  out  $clog2(NUM_CHECKS)  index of first failing entry
fail_valid  out  1  fail_idx holds a failure

Behaviour:
- Reset: all outputs 0; state IDLE; step index 0; table contents undefined (not cleared).
- States: IDLE, STEP, WAIT, CHECK, DONE.
- IDLE: on start, go to STEP; set busy=1; clear done/pass/err_count/fail_valid; latch num_steps (0 is treated as 1; values > NUM_CHECKS clamp to NUM_CHECKS); set idx=0.
- STEP: assert cpu_step for exactly one cycle; load timeout counter with TIMEOUT_CYCLES; go to WAIT.
- WAIT: on commit_valid, register the commit and go to CHECK. Otherwise decrement the counter; at 0, record a timeout failure for idx and go to CHECK with the compare forced to fail.
- A commit_valid arriving in the same cycle as cpu_step is accepted.
- A commit_valid in IDLE, DONE or CHECK is ignored.
- CHECK, one cycle:
  - SKIP entries always pass, but WAIT still requires a commit.
  - Otherwise pass iff kind, target and data all match; for kind PC, only data is compared.
  - On fail: err_count += 1 (saturating at all-ones). If !fail_valid, set fail_idx=idx and fail_valid=1.
  - Then if idx == last entry, go to DONE; else idx += 1 and go to STEP.
- DONE: busy=0, done=1, pass=(err_count==0). Go to IDLE when start is next seen, processing that start in the same cycle.
- Minimum per-step latency is 3 cycles (STEP, WAIT with immediate commit, CHECK). Total run time for N entries with immediate commits is 3N+1 cycles from start to done.
- start while busy: ignored. exp_we while busy: ignored (table frozen).
- Reset mid-run: immediate return to IDLE, outputs 0, cpu_step deasserted asynchronously.

Optional Feature:
STOP_ON_FAIL_EN
- Defined: the first failing CHECK goes directly to DONE; no further cpu_step pulses are issued; err_count == 1.
- Undefined: the run continues through all entries, accumulating err_count.

Test Plan:
- Load 3 entries (REG r0=0001, REG r1=0002, REG r2=0003). Model the core so each commit arrives 1 cycle after cpu_step with matching data; start with num_steps=3 -> exactly 3 cpu_step pulses; done after 10 cycles; pass=1; err_count=0; fail_valid=0.
- Entry 1 expects MEM addr 2 = 0003, core commits MEM addr 2 = 0004; num_steps=4 -> pass=0, err_count=1, fail_idx=1.
- Entry 2 PC=000D, core commits REG target 5 with data 000D -> kind mismatch; fail_idx=2.
- Core never commits on entry 0, TIMEOUT_CYCLES=8 -> CHECK reached 9 cycles after cpu_step; err_count=1; the run continues to the remaining entries (without STOP_ON_FAIL_EN).
- With STOP_ON_FAIL_EN and failures at entries 1 and 3 of 5 -> exactly 2 cpu_step pulses; done; err_count=1; fail_idx=1.
- Assert rst_n low during WAIT of entry 2 -> busy, done and cpu_step drop immediately. A new start after reset release runs from entry 0 with the table intact.

Source files
------------

// File: rtl/risc_step_checker.sv
// Single-step controller and commit checker for the Risc16 core: steps the core one instruction at a time and scores each commit against a loadable table.
// Optional macro STOP_ON_FAIL_EN ends the run at the first failing entry.
module risc_step_checker #(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 16,
   parameter int NUM_CHECKS     = 16,
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic [$clog2(NUM_CHECKS):0]     num_steps,
   input  logic                            exp_we,
   input  logic [$clog2(NUM_CHECKS)-1:0]   exp_idx,
   input  logic [1:0]                      exp_kind,
   input  logic [ADDR_WIDTH-1:0]           exp_target,
   input  logic [DATA_WIDTH-1:0]           exp_data,
   output logic                            cpu_step,
   input  logic                            commit_valid,
   input  logic [1:0]                      commit_kind,
   input  logic [ADDR_WIDTH-1:0]           commit_target,
   input  logic [DATA_WIDTH-1:0]           commit_data,
   output logic                            busy,
   output logic                            done,
   output logic                            pass,
   output logic [$clog2(NUM_CHECKS):0]     err_count,
   output logic [$clog2(NUM_CHECKS)-1:0]   fail_idx,
   output logic                            fail_valid
);

   localparam int IDX_W = $clog2(NUM_CHECKS);
   localparam int CNT_W = IDX_W + 1;
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [1:0] KIND_PC   = 2'b10;
   localparam logic [1:0] KIND_SKIP = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_STEP, S_WAIT, S_CHECK, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [IDX_W-1:0]        last_q, last_d;
   logic [TMR_W-1:0]        tmr_q, tmr_d;
   logic                    got_q, got_d;
   logic                    timeout_q, timeout_d;
   logic [1:0]              cmt_kind_q, cmt_kind_d;
   logic [ADDR_WIDTH-1:0]   cmt_target_q, cmt_target_d;
   logic [DATA_WIDTH-1:0]   cmt_data_q, cmt_data_d;
   logic                    done_q, done_d;
   logic                    pass_q, pass_d;
   logic [CNT_W-1:0]        err_q, err_d;
   logic [IDX_W-1:0]        fail_idx_q, fail_idx_d;
   logic                    fail_valid_q, fail_valid_d;

   logic [1:0]              tbl_kind   [NUM_CHECKS];
   logic [ADDR_WIDTH-1:0]   tbl_target [NUM_CHECKS];
   logic [DATA_WIDTH-1:0]   tbl_data   [NUM_CHECKS];

   logic [CNT_W-1:0]        num_eff;
   logic                    mismatch;
   logic                    check_fail;
   logic                    run_end;

   assign cpu_step   = (state_q == S_STEP);
   assign busy       = (state_q == S_STEP) || (state_q == S_WAIT) || (state_q == S_CHECK);
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign fail_idx   = fail_idx_q;
   assign fail_valid = fail_valid_q;

   // Expectation table is not reset and is frozen for the duration of a run.
   always_ff @(posedge clk) begin
      if (exp_we && !busy) begin
         tbl_kind[exp_idx]   <= exp_kind;
         tbl_target[exp_idx] <= exp_target;
         tbl_data[exp_idx]   <= exp_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         last_q       <= '0;
         tmr_q        <= '0;
         got_q        <= 1'b0;
         timeout_q    <= 1'b0;
         cmt_kind_q   <= '0;
         cmt_target_q <= '0;
         cmt_data_q   <= '0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_q        <= '0;
         fail_idx_q   <= '0;
         fail_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         last_q       <= last_d;
         tmr_q        <= tmr_d;
         got_q        <= got_d;
         timeout_q    <= timeout_d;
         cmt_kind_q   <= cmt_kind_d;
         cmt_target_q <= cmt_target_d;
         cmt_data_q   <= cmt_data_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         err_q        <= err_d;
         fail_idx_q   <= fail_idx_d;
         fail_valid_q <= fail_valid_d;
      end
   end

   always_comb begin
      if (num_steps == '0)
         num_eff = CNT_W'(1);
      else if (num_steps > CNT_W'(NUM_CHECKS))
         num_eff = CNT_W'(NUM_CHECKS);
      else
         num_eff = num_steps;
   end

   // PC commits carry no meaningful target, so only data is scored for them.
   always_comb begin
      mismatch = (cmt_kind_q != tbl_kind[idx_q])
              || ((tbl_kind[idx_q] != KIND_PC) && (cmt_target_q != tbl_target[idx_q]))
              || (cmt_data_q != tbl_data[idx_q]);
      check_fail = timeout_q || ((tbl_kind[idx_q] != KIND_SKIP) && mismatch);
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      last_d       = last_q;
      tmr_d        = tmr_q;
      got_d        = got_q;
      timeout_d    = timeout_q;
      cmt_kind_d   = cmt_kind_q;
      cmt_target_d = cmt_target_q;
      cmt_data_d   = cmt_data_q;
      done_d       = done_q;
      pass_d       = pass_q;
      err_d        = err_q;
      fail_idx_d   = fail_idx_q;
      fail_valid_d = fail_valid_q;
      run_end      = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d      = S_STEP;
               idx_d        = '0;
               last_d       = IDX_W'(num_eff - CNT_W'(1));
               done_d       = 1'b0;
               pass_d       = 1'b0;
               err_d        = '0;
               fail_idx_d   = '0;
               fail_valid_d = 1'b0;
            end
         end
         S_STEP: begin
            state_d   = S_WAIT;
            tmr_d     = TMR_W'(TIMEOUT_CYCLES);
            timeout_d = 1'b0;
            got_d     = commit_valid;
            if (commit_valid) begin
               cmt_kind_d   = commit_kind;
               cmt_target_d = commit_target;
               cmt_data_d   = commit_data;
            end
         end
         S_WAIT: begin
            if (got_q) begin
               state_d = S_CHECK;
            end else if (commit_valid) begin
               state_d      = S_CHECK;
               cmt_kind_d   = commit_kind;
               cmt_target_d = commit_target;
               cmt_data_d   = commit_data;
            end else if (tmr_q <= TMR_W'(1)) begin
               state_d   = S_CHECK;
               timeout_d = 1'b1;
               tmr_d     = '0;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         S_CHECK: begin
            if (check_fail) begin
               if (err_q != '1)
                  err_d = err_q + CNT_W'(1);
               if (!fail_valid_q) begin
                  fail_idx_d   = idx_q;
                  fail_valid_d = 1'b1;
               end
            end
`ifdef STOP_ON_FAIL_EN
            run_end = (idx_q == last_q) || check_fail;
`else
            run_end = (idx_q == last_q);
`endif
            if (run_end) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
            end else begin
               state_d = S_STEP;
               idx_d   = idx_q + IDX_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_risc_step_checker.sv
// Scoreboard bench for risc_step_checker: a behavioural core answers cpu_step pulses, expected run verdicts are queued at start and compared at done.
module tb_risc_step_checker;

   localparam logic [1:0] REG  = 2'b00;
   localparam logic [1:0] MEM  = 2'b01;
   localparam logic [1:0] PC   = 2'b10;
   localparam logic [1:0] SKIP = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  num_steps = '0;
   logic        exp_we = 1'b0;
   logic [3:0]  exp_idx = '0;
   logic [1:0]  exp_kind = '0;
   logic [15:0] exp_target = '0;
   logic [15:0] exp_data = '0;
   logic        cpu_step;
   logic        commit_valid = 1'b0;
   logic [1:0]  commit_kind = '0;
   logic [15:0] commit_target = '0;
   logic [15:0] commit_data = '0;
   logic        busy, done, pass, fail_valid;
   logic [4:0]  err_count;
   logic [3:0]  fail_idx;

   typedef struct {
      int pass;
      int err;
      int fidx;
      int fvalid;
      int steps;
      int cycles;
   } expect_t;

   expect_t     sb[$];
   int          checks = 0;
   int          failures = 0;
   int          stepTotal = 0;
   int          runBase = 0;
   int          pendCnt = 0;
   int          pendIdx = 0;

   logic [1:0]  coreKind   [16];
   logic [15:0] coreTarget [16];
   logic [15:0] coreData   [16];
   int          coreDelay  [16];

   risc_step_checker dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_steps(num_steps),
      .exp_we(exp_we), .exp_idx(exp_idx), .exp_kind(exp_kind),
      .exp_target(exp_target), .exp_data(exp_data), .cpu_step(cpu_step),
      .commit_valid(commit_valid), .commit_kind(commit_kind),
      .commit_target(commit_target), .commit_data(commit_data),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .fail_idx(fail_idx), .fail_valid(fail_valid)
   );

   always #5 clk = ~clk;

   // Behavioural core: each cpu_step pulse answers with the scripted commit after
   // coreDelay cycles (0 = same cycle as the step, negative = never).
   always @(negedge clk) begin
      int k;
      commit_valid = 1'b0;
      if (pendCnt > 0) begin
         pendCnt--;
         if (pendCnt == 0) begin
            commit_valid  = 1'b1;
            commit_kind   = coreKind[pendIdx];
            commit_target = coreTarget[pendIdx];
            commit_data   = coreData[pendIdx];
         end
      end
      if (cpu_step) begin
         k = stepTotal - runBase;
         stepTotal++;
         if (k >= 0 && k < 16) begin
            if (coreDelay[k] == 0) begin
               commit_valid  = 1'b1;
               commit_kind   = coreKind[k];
               commit_target = coreTarget[k];
               commit_data   = coreData[k];
            end else if (coreDelay[k] > 0) begin
               pendCnt = coreDelay[k];
               pendIdx = k;
            end
         end
      end
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic setEntry(input int i, input logic [1:0] ek, input logic [15:0] et,
                           input logic [15:0] ed, input logic [1:0] ck,
                           input logic [15:0] ct, input logic [15:0] cd, input int dly);
      coreKind[i]   = ck;
      coreTarget[i] = ct;
      coreData[i]   = cd;
      coreDelay[i]  = dly;
      @(negedge clk);
      exp_we     = 1'b1;
      exp_idx    = 4'(i);
      exp_kind   = ek;
      exp_target = et;
      exp_data   = ed;
      @(posedge clk);
      #1 exp_we = 1'b0;
   endtask

   task automatic setMatch(input int i, input logic [1:0] k, input logic [15:0] t,
                           input logic [15:0] d);
      setEntry(i, k, t, d, k, t, d, 1);
   endtask

   // Queue the expected verdict, pulse start, then pop and score once done rises.
   task automatic applyStimulus(input int num, input int ePass, input int eErr,
                                input int eFidx, input int eFvalid, input int eSteps,
                                input int eCycles, input bit disturb);
      expect_t e;
      int cycles;
      bit gotDone;
      e.pass = ePass; e.err = eErr; e.fidx = eFidx; e.fvalid = eFvalid;
      e.steps = eSteps; e.cycles = eCycles;
      sb.push_back(e);
      @(negedge clk);
      runBase   = stepTotal;
      num_steps = 5'(num);
      start     = 1'b1;
      cycles    = 0;
      gotDone   = 1'b0;
      while (cycles < 300 && !gotDone) begin
         @(posedge clk);
         #1 cycles++;
         if (cycles == 1) start = 1'b0;
         if (disturb && cycles == 4) begin
            start      = 1'b1;
            num_steps  = 5'd1;
            exp_we     = 1'b1;
            exp_idx    = 4'd0;
            exp_data   = 16'hDEAD;
         end
         if (disturb && cycles == 5) begin
            start  = 1'b0;
            exp_we = 1'b0;
         end
         if (done) gotDone = 1'b1;
      end
      e = sb.pop_front();
      checkOutput("doneSeen", int'(gotDone), 1);
      checkOutput("cycles", cycles, e.cycles);
      checkOutput("pass", int'(pass), e.pass);
      checkOutput("errCount", int'(err_count), e.err);
      checkOutput("failValid", int'(fail_valid), e.fvalid);
      if (e.fvalid != 0) checkOutput("failIdx", int'(fail_idx), e.fidx);
      checkOutput("busyAtDone", int'(busy), 0);
      @(posedge clk);
      #1 checkOutput("doneHeld", int'(done), 1);
      checkOutput("stepPulses", stepTotal - runBase, e.steps);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         coreKind[i] = REG; coreTarget[i] = '0; coreData[i] = '0; coreDelay[i] = 1;
      end
      #12;
      checkOutput("rstBusy", int'(busy), 0);
      checkOutput("rstDone", int'(done), 0);
      checkOutput("rstPass", int'(pass), 0);
      checkOutput("rstErr", int'(err_count), 0);
      checkOutput("rstFailValid", int'(fail_valid), 0);
      checkOutput("rstCpuStep", int'(cpu_step), 0);
      @(negedge clk);
      rst_n = 1'b1;

      setMatch(0, REG, 16'd0, 16'h0001);
      setMatch(1, REG, 16'd1, 16'h0002);
      setMatch(2, REG, 16'd2, 16'h0003);
      applyStimulus(3, 1, 0, 0, 0, 3, 10, 1'b0);
      // start and table writes during the run must be ignored
      applyStimulus(3, 1, 0, 0, 0, 3, 10, 1'b1);
      // num_steps 0 runs one entry; entry 0 must still hold its original value
      applyStimulus(0, 1, 0, 0, 0, 1, 4, 1'b0);

      setEntry(1, MEM, 16'd2, 16'h0003, MEM, 16'd2, 16'h0004, 1);
      setMatch(3, REG, 16'd3, 16'h0004);
      applyStimulus(4, 0, 1, 1, 1, 4, 13, 1'b0);

      setMatch(1, REG, 16'd1, 16'h0002);
      setEntry(2, PC, 16'd0, 16'h000D, REG, 16'd5, 16'h000D, 1);
      applyStimulus(3, 0, 1, 2, 1, 3, 10, 1'b0);

      // PC ignores target, SKIP ignores content, same-cycle commit is accepted
      setEntry(1, PC, 16'd0, 16'h0020, PC, 16'h0055, 16'h0020, 1);
      setEntry(2, SKIP, 16'd0, 16'd0, MEM, 16'd9, 16'h1234, 1);
      setEntry(3, REG, 16'd3, 16'h0004, REG, 16'd3, 16'h0004, 0);
      applyStimulus(4, 1, 0, 0, 0, 4, 13, 1'b0);

      setEntry(2, REG, 16'd7, 16'h0055, REG, 16'd6, 16'h0055, 1);
      applyStimulus(4, 0, 1, 2, 1, 4, 13, 1'b0);

      setEntry(0, REG, 16'd0, 16'h0001, REG, 16'd0, 16'h0001, -1);
      setMatch(1, REG, 16'd1, 16'h0002);
      setMatch(2, REG, 16'd2, 16'h0003);
`ifdef STOP_ON_FAIL_EN
      applyStimulus(3, 0, 1, 0, 1, 1, 11, 1'b0);
`else
      applyStimulus(3, 0, 1, 0, 1, 3, 17, 1'b0);
`endif

      setMatch(0, REG, 16'd0, 16'h0001);
      setEntry(1, REG, 16'd1, 16'h0002, REG, 16'd1, 16'h0003, 1);
      setMatch(2, REG, 16'd2, 16'h0003);
      setEntry(3, REG, 16'd3, 16'h0004, REG, 16'd3, 16'h0005, 1);
      setMatch(4, REG, 16'd4, 16'h0005);
`ifdef STOP_ON_FAIL_EN
      applyStimulus(5, 0, 1, 1, 1, 2, 7, 1'b0);
`else
      applyStimulus(5, 0, 2, 1, 1, 5, 16, 1'b0);
`endif

      for (int i = 0; i < 16; i++) setMatch(i, REG, 16'(i), 16'(i * 3 + 1));
      applyStimulus(20, 1, 0, 0, 0, 16, 49, 1'b0);

      // Reset while waiting on entry 2, then rerun against the untouched table
      coreDelay[2] = -1;
      @(negedge clk);
      runBase   = stepTotal;
      num_steps = 5'd3;
      start     = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 0; c < 100 && (stepTotal - runBase) < 3; c++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("thirdStepSeen", stepTotal - runBase, 3);
      @(posedge clk);
      #1 checkOutput("busyBeforeReset", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midRstBusy", int'(busy), 0);
      checkOutput("midRstDone", int'(done), 0);
      checkOutput("midRstCpuStep", int'(cpu_step), 0);
      checkOutput("midRstErr", int'(err_count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      coreDelay[2] = 1;
      applyStimulus(3, 1, 0, 0, 0, 3, 10, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
